// File: rtl/mb_uart_console.sv
`default_nettype none
// ============================================================================
// Module      : mb_uart_console
// Description : 8N1 UART console. Sends an "OK\r\n" banner after reset, then
//               echoes every correctly received byte through a one-entry
//               holding register. The last good byte is shown on LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_uart_console #(
    parameter int CLKS_PER_BIT = 16,
    parameter int LED_WIDTH    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic [LED_WIDTH-1:0] led_tri_o,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 tx_busy
);

    localparam int              c_cnt_w      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]      c_banner_len = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Banner character lookup: "OK\r\n"
    function automatic logic [7:0] f_banner(input logic [2:0] idx);
        case (idx)
            3'd0:    f_banner = 8'h4F;
            3'd1:    f_banner = 8'h4B;
            3'd2:    f_banner = 8'h0D;
            3'd3:    f_banner = 8'h0A;
            default: f_banner = 8'h00;
        endcase
    endfunction

    // ---------------- receive side ----------------
    logic                r_rxd_meta, r_rxd_sync, r_rxd_prev;
    uart_state_t         r_rx_state, w_rx_state_nxt;
    logic [c_cnt_w-1:0]  r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]          r_rx_bit, w_rx_bit_nxt;
    logic [7:0]          r_rx_shift, w_rx_shift_nxt;
    logic [7:0]          r_rx_data;
    logic                r_rx_valid, r_frame_err;
    logic                w_rx_good, w_rx_bad;

    // ---------------- transmit side ----------------
    uart_state_t         r_tx_state, w_tx_state_nxt;
    logic [c_cnt_w-1:0]  r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]          r_tx_bit, w_tx_bit_nxt;
    logic [7:0]          r_tx_shift, w_tx_shift_nxt;
    logic [2:0]          r_ban_idx;
    logic                r_hold_full;
    logic [7:0]          r_hold_data;
    logic                r_overrun;
    logic                w_ban_active, w_tx_avail, w_tx_load, w_hold_pop;
    logic [7:0]          w_tx_src;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // RX next-state: sample mid-bit, glitch filter at half a start bit
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + c_cnt_w'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_good      = 1'b0;
        w_rx_bad       = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rxd_prev && !r_rxd_sync) begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_rx_cnt == c_cnt_half) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = r_rxd_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == c_cnt_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rxd_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == c_cnt_last) begin
                    w_rx_state_nxt = ST_IDLE;
                    w_rx_good      = r_rxd_sync;
                    w_rx_bad       = !r_rxd_sync;
                end
            end
            default: w_rx_state_nxt = ST_IDLE;
        endcase
    end

    // RX state register and received-byte outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_state  <= ST_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_rx_bit    <= w_rx_bit_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_rx_valid  <= w_rx_good;
            r_frame_err <= w_rx_bad;
            if (w_rx_good) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    // TX next-state: banner has priority over the echo holding register;
    // a new byte is loaded straight from the end of STOP to keep frames back-to-back
    always_comb begin
        w_ban_active   = (r_ban_idx != c_banner_len);
        w_tx_avail     = w_ban_active || r_hold_full;
        w_tx_src       = w_ban_active ? f_banner(r_ban_idx) : r_hold_data;
        w_tx_load      = 1'b0;
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + c_cnt_w'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_load    = w_tx_avail;
            end
            ST_START: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = ST_IDLE;
                    w_tx_load      = w_tx_avail;
                end
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_state_nxt = ST_START;
            w_tx_cnt_nxt   = '0;
            w_tx_shift_nxt = w_tx_src;
        end
        w_hold_pop = w_tx_load && !w_ban_active;
    end

    // TX state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
        end
    end

    // Banner index, echo holding register and sticky overrun; a byte arriving
    // as the held byte leaves for TX is accepted
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ban_idx   <= 3'd0;
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
            r_overrun   <= 1'b0;
        end else begin
            if (w_tx_load && w_ban_active) begin
                r_ban_idx <= r_ban_idx + 3'd1;
            end
            if (w_rx_good) begin
                if (r_hold_full && !w_hold_pop) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_hold_full <= 1'b1;
                    r_hold_data <= r_rx_shift;
                end
            end else if (w_hold_pop) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign uart_txd  = (r_tx_state == ST_START) ? 1'b0 :
                       (r_tx_state == ST_DATA)  ? r_tx_shift[0] : 1'b1;
    assign tx_busy   = (r_tx_state != ST_IDLE);
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    generate
        if (LED_WIDTH > 8) begin : g_led_ext
            assign led_tri_o = {{(LED_WIDTH-8){1'b0}}, r_rx_data};
        end else begin : g_led_trunc
            assign led_tri_o = r_rx_data[LED_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mb_uart_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_mb_uart_console
// Description : Self-checking bench for mb_uart_console with a queue-based
//               reference model of banner, echo and receive behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_uart_console;

    localparam int CPB = 16;

    logic       clock;
    logic       reset;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] led_tri_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       tx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ferr  = 0;

    logic [8:0] obs_tx[$];
    int         obs_start[$];
    logic [7:0] obs_rx[$];
    logic [8:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    mb_uart_console #(.CLKS_PER_BIT(CPB), .LED_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd),
        .led_tri_o (led_tri_o),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .tx_busy   (tx_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial-line monitor: decodes each frame on uart_txd at mid-bit points
    initial begin
        bit         in_frame;
        int         t;
        int         s;
        logic [7:0] b;
        in_frame = 0;
        t = 0;
        s = 0;
        b = 8'h00;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                in_frame = 0;
            end else if (!in_frame) begin
                if (uart_txd === 1'b0) begin
                    in_frame = 1;
                    t = 0;
                    s = cyc;
                end
            end else begin
                t++;
                for (int i = 0; i < 8; i++) begin
                    if (t == CPB/2 + (i+1)*CPB) b[i] = uart_txd;
                end
                if (t == CPB/2 + 9*CPB) begin
                    obs_tx.push_back({uart_txd, b});
                    obs_start.push_back(s);
                    in_frame = 0;
                end
            end
        end
    end

    // Receive-side monitor
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && rx_valid === 1'b1) obs_rx.push_back(rx_data);
            if (reset === 1'b1 && frame_err === 1'b1) n_ferr++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic glitch();
        uart_rxd = 1'b0;
        repeat (4) @(negedge clock);
        uart_rxd = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"},      32'(uart_txd),  32'd1);
        check({tag, "_led"},      32'(led_tri_o), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data),   32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid),  32'd0);
        check({tag, "_ferr"},     32'(frame_err), 32'd0);
        check({tag, "_overrun"},  32'(overrun),   32'd0);
        check({tag, "_tx_busy"},  32'(tx_busy),   32'd0);
    endtask

    task automatic wait_tx(input int count, input int budget);
        for (int k = 0; k < budget && obs_tx.size() < count; k++) @(negedge clock);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_tx_count"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(obs_tx[i]), 32'(exp_tx[i]));
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_rx_count"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(obs_rx[i]), 32'(exp_rx[i]));
    endtask

    task automatic clear_all();
        obs_tx.delete();
        obs_start.delete();
        obs_rx.delete();
        exp_tx.delete();
        exp_rx.delete();
    endtask

    task automatic push_banner();
        logic [7:0] ban[4];
        ban = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        for (int i = 0; i < 4; i++) exp_tx.push_back({1'b1, ban[i]});
    endtask

    task automatic check_banner_timing(input string tag, input int rel);
        for (int k = 0; k < 4 && k < obs_start.size(); k++)
            check($sformatf("%s_start%0d", tag, k), 32'(obs_start[k]), 32'(rel + 1 + k*10*CPB));
    endtask

    initial begin
        int         rel;
        int         ferr0;
        int         rx0;
        logic [7:0] b;
        logic       good;
        int         gap;

        reset    = 1'b0;
        uart_rxd = 1'b1;
        repeat (5) @(negedge clock);
        check_reset_outputs("rst0");

        // Banner with three bytes arriving during it
        push_banner();
        exp_tx.push_back({1'b1, 8'h11});
        exp_rx = '{8'h11, 8'h22, 8'h33};
        reset = 1'b1;
        rel   = cyc;
        repeat (10) @(negedge clock);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        wait_tx(5, 3000);
        repeat (2*CPB) @(negedge clock);
        compare_tx("ban1");
        check_banner_timing("ban1", rel);
        compare_rx("ban1");
        check("ban1_overrun", 32'(overrun),   32'd1);
        check("ban1_led",     32'(led_tri_o), 32'h33);
        check("ban1_rx_data", 32'(rx_data),   32'h33);
        check("ban1_idle",    32'(tx_busy),   32'd0);
        clear_all();

        // Reset in the middle of an echo frame
        send_frame(8'h5A, 1'b1);
        repeat (40) @(negedge clock);
        check("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("rst1");
        repeat (40) @(negedge clock);
        check("rst1_no_partial", 32'(obs_tx.size()), 32'd0);
        clear_all();

        // Banner restarts after release
        push_banner();
        reset = 1'b1;
        rel   = cyc;
        wait_tx(4, 2000);
        repeat (4*CPB) @(negedge clock);
        compare_tx("ban2");
        check_banner_timing("ban2", rel);
        clear_all();

        // Echo mode: directed good byte, bad stop bit, short glitch
        n_ferr = 0;
        send_frame(8'hA5, 1'b1);
        exp_rx.push_back(8'hA5);
        exp_tx.push_back({1'b1, 8'hA5});
        check("a5_rx_data", 32'(rx_data),   32'hA5);
        check("a5_led",     32'(led_tri_o), 32'hA5);
        send_frame(8'h3C, 1'b0);
        repeat (CPB) @(negedge clock);
        check("3c_ferr", 32'(n_ferr),    32'd1);
        check("3c_led",  32'(led_tri_o), 32'hA5);
        ferr0 = n_ferr;
        rx0   = obs_rx.size();
        glitch();
        repeat (3*CPB) @(negedge clock);
        check("glitch_rx",   32'(obs_rx.size()), 32'(rx0));
        check("glitch_ferr", 32'(n_ferr),        32'(ferr0));

        // Randomized echo traffic
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                glitch();
                repeat (CPB) @(negedge clock);
            end
            send_frame(b, good);
            if (good) begin
                exp_rx.push_back(b);
                exp_tx.push_back({1'b1, b});
            end else begin
                ferr0++;
            end
            gap = good ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            repeat (gap*CPB) @(negedge clock);
        end
        wait_tx(exp_tx.size(), 4000);
        repeat (2*CPB) @(negedge clock);
        compare_tx("echo");
        compare_rx("echo");
        check("echo_ferr",    32'(n_ferr),  32'(ferr0));
        check("echo_overrun", 32'(overrun), 32'd0);
        check("echo_idle",    32'(tx_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
